nios2_oci_dct_packer: RTL

- Producer side of the OCI data-capture-trace (DCT) interface.
- Accepts 2-bit trace atoms from the CPU trace logic and packs them LSB-first into a 30-bit DCT buffer, exporting the live buffer and its atom count.
- Hands completed 30-bit words to trace memory over a valid/ready handshake.
- On test_ending, flushes any partial word, then asserts test_has_ended for the simulation monitor.

---
 rtl/nios2_oci_dct_packer.sv | 108 ++++++++++
 1 files changed

// File: rtl/nios2_oci_dct_packer.sv
// Producer side of the OCI data-capture-trace interface: packs 2-bit trace atoms
// LSB-first into 30-bit words and hands them to trace memory, with an end-of-test flush.
module nios2_oci_dct_packer #(
  parameter  int ATOM_W         = 2,
  parameter  int ATOMS_PER_WORD = 15,
  parameter  int CNT_W          = 4,
  localparam int BUF_W          = ATOM_W * ATOMS_PER_WORD
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom_data,
  output logic              atom_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              word_valid,
  output logic [BUF_W-1:0]  word_data,
  output logic [CNT_W-1:0]  word_count,
  input  logic              word_ready,
  input  logic              test_ending,
  output logic              test_has_ended
);

  typedef enum logic [1:0] {RUN, FLUSH, ENDED} state_e;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(ATOMS_PER_WORD);

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wv_q, wv_d;
  logic [BUF_W-1:0]   wd_q, wd_d;
  logic [CNT_W-1:0]   wc_q, wc_d;

  logic slot_free, accept, xfer;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (test_ending) state_d = FLUSH;
      FLUSH:   if (cnt_q == '0 && slot_free) state_d = ENDED;
      default: state_d = ENDED;
    endcase
  end

  // Outputs that depend on state only, so atom_ready never loops back through atom_valid
  always_comb begin
    atom_ready     = (state_q == RUN) && (cnt_q != FULL);
    test_has_ended = (state_q == ENDED);
  end

  assign slot_free = !wv_q || word_ready;
  assign accept    = atom_valid && atom_ready;
  // A full buffer can never accept, so transfer and accept are mutually exclusive
  assign xfer      = slot_free && (((state_q == RUN) && (cnt_q == FULL)) ||
                                   ((state_q == FLUSH) && (cnt_q != '0)));

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    wv_d  = wv_q;
    wd_d  = wd_q;
    wc_d  = wc_q;
    if (xfer) begin
      wd_d  = buf_q;
      wc_d  = cnt_q;
      wv_d  = 1'b1;
      buf_d = '0;
      cnt_d = '0;
    end else begin
      if (word_ready) wv_d = 1'b0;
      if (accept) begin
        buf_d = buf_q | (BUF_W'(atom_data) << (ATOM_W * cnt_q));
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buf_q <= '0;
      cnt_q <= '0;
      wv_q  <= 1'b0;
      wd_q  <= '0;
      wc_q  <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      wv_q  <= wv_d;
      wd_q  <= wd_d;
      wc_q  <= wc_d;
    end
  end

  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;
  assign word_valid = wv_q;
  assign word_data  = wd_q;
  assign word_count = wc_q;

endmodule
